// File: rtl/dma_pkg.sv
// Shared widths and FSM state encoding for the memory copy/fill engine.
package dma_pkg;
    localparam int DMA_AW = 8;
    localparam int DMA_DW = 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copy_engine.sv
// Block copy engine driving a byte-wide memory with combinational read data.
// Define DMA_FILL_EN to add constant-fill mode (fill_mode / fill_value ports).
module mem_copy_engine
    import dma_pkg::*;
#(
    parameter int AW = DMA_AW,
    parameter int DW = DMA_DW
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
`ifdef DMA_FILL_EN
    input  logic          fill_mode,
    input  logic [DW-1:0] fill_value,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] DataAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut
);

    state_t        state;
    logic [AW-1:0] i;
    logic [AW-1:0] i_next;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW-1:0] len_r;
    logic [DW-1:0] hold;
    logic          fill_r;
    logic          fill_req;
    logic [DW-1:0] fill_data;

`ifdef DMA_FILL_EN
    assign fill_req  = fill_mode;
    assign fill_data = fill_value;
`else
    assign fill_req  = 1'b0;
    assign fill_data = '0;
`endif

    assign i_next = i + AW'(1);

    // hold doubles as the write-data register; gating keeps the bus at 0 outside writes
    assign DataIn = WriteMem ? hold : '0;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            hold        <= '0;
            src_r       <= '0;
            dst_r       <= '0;
            len_r       <= '0;
            fill_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            DataAddress <= '0;
            ReadMem     <= 1'b0;
            WriteMem    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_r  <= src;
                        dst_r  <= dst;
                        len_r  <= len;
                        fill_r <= fill_req;
                        i      <= '0;
                        busy   <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (fill_req) begin
                            state       <= WRITE;
                            WriteMem    <= 1'b1;
                            DataAddress <= dst;
                            hold        <= fill_data;
                        end else begin
                            state       <= READ;
                            ReadMem     <= 1'b1;
                            DataAddress <= src;
                        end
                    end
                end
                READ: begin
                    hold        <= DataOut;
                    ReadMem     <= 1'b0;
                    WriteMem    <= 1'b1;
                    DataAddress <= dst_r + i;
                    state       <= WRITE;
                end
                WRITE: begin
                    i <= i_next;
                    if (i_next == len_r) begin
                        state       <= DONE;
                        WriteMem    <= 1'b0;
                        DataAddress <= '0;
                        done        <= 1'b1;
                    end else if (fill_r) begin
                        // fill stays in WRITE, one byte per cycle, hold keeps the fill constant
                        DataAddress <= dst_r + i_next;
                    end else begin
                        state       <= READ;
                        WriteMem    <= 1'b0;
                        ReadMem     <= 1'b1;
                        DataAddress <= src_r + i_next;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed cases plus random copies
// against a byte-array reference model of the memory.
module tb_mem_copy_engine;
    import dma_pkg::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src = '0;
    logic [7:0] dst = '0;
    logic [7:0] len = '0;
`ifdef DMA_FILL_EN
    logic       fill_mode = 1'b0;
    logic [7:0] fill_value = '0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .CLK(CLK),
        .reset(reset),
        .start(start),
        .src(src),
        .dst(dst),
        .len(len),
`ifdef DMA_FILL_EN
        .fill_mode(fill_mode),
        .fill_value(fill_value),
`endif
        .busy(busy),
        .done(done),
        .DataAddress(DataAddress),
        .ReadMem(ReadMem),
        .WriteMem(WriteMem),
        .DataIn(DataIn),
        .DataOut(DataOut)
    );

    always #5 CLK = ~CLK;

    // Data memory: combinational read, synchronous write; ld_* preloads contents
    assign DataOut = mem[DataAddress];
    always @(posedge CLK) begin
        if (WriteMem) mem[DataAddress] <= DataIn;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        for (int k = 0; k < 256; k++) begin
            @(posedge CLK); #1;
            ld_en = 1'b1; ld_addr = 8'(k); ld_data = ref_mem[k];
        end
        @(posedge CLK); #1;
        ld_en = 1'b0;
    endtask

    task automatic compare_mem(input string tag);
        for (int k = 0; k < 256; k++) check(tag, {24'd0, mem[k]}, {24'd0, ref_mem[k]});
    endtask

    // One operation; inj>0 pulses a foreign start in that cycle, rc>0 asserts reset in that cycle.
    task automatic run_op(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit fm, input logic [7:0] fv, input int inj, input int rc);
        int total;
        int dones;
        int k;
        logic       rd, wr, dn, bz;
        logic [7:0] a, din;
        if (l == 0) total = 1;
        else if (fm) total = int'(l) + 1;
        else total = 2 * int'(l) + 1;
        @(posedge CLK); #1;
        start = 1'b1; src = s; dst = d; len = l;
`ifdef DMA_FILL_EN
        fill_mode = fm; fill_value = fv;
`endif
        @(posedge CLK); #1;
        start = 1'b0; src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
        dones = 0;
        for (int c = 1; c <= total + 1; c++) begin
            if (c > 1) begin @(posedge CLK); #1; end
            if (c == rc) begin
                reset = 1'b1; #1;
                check("rst_bus", {19'd0, busy, done, ReadMem, WriteMem, DataAddress, DataIn}, 32'd0);
                check("rst_state", 32'(dut.state), 32'(IDLE));
                @(posedge CLK); #1;
                reset = 1'b0;
                for (int e = 0; e < 2 * int'(l) + 4; e++) begin
                    @(posedge CLK); #1;
                    dones += int'(done);
                end
                check("rst_no_done", dones, 0);
                return;
            end
            rd = 0; wr = 0; dn = 0; bz = 1; a = '0; din = '0;
            if (c == total) dn = 1;
            else if (c > total) bz = 0;
            else if (fm) begin
                wr = 1; a = 8'(int'(d) + c - 1); din = fv; ref_mem[a] = din;
            end else if (c % 2 == 1) begin
                rd = 1; a = 8'(int'(s) + (c - 1) / 2);
            end else begin
                k = c / 2 - 1;
                wr = 1; a = 8'(int'(d) + k); din = ref_mem[8'(int'(s) + k)]; ref_mem[a] = din;
            end
            check("cycle", {20'd0, busy, done, ReadMem, WriteMem, DataAddress},
                  {20'd0, bz, dn, rd, wr, a});
            if (wr) check("din", {24'd0, DataIn}, {24'd0, din});
            dones += int'(done);
            if (c == inj) begin
                start = 1'b1; src = 8'd0; dst = 8'd200; len = 8'd5;
            end else start = 1'b0;
        end
        start = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge CLK); #1;
            dones += int'(done);
        end
        check("one_done", dones, 1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'd0;
        ref_mem[16]  = 8'd254;
        ref_mem[244] = 8'd5;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {19'd0, busy, done, ReadMem, WriteMem, DataAddress, DataIn}, 32'd0);
        reset = 1'b0;
        load_mem();
        compare_mem("init_mem");

        run_op(8'd16, 8'd32, 8'd1, 1'b0, 8'd0, 0, 0);
        check("m32", {24'd0, mem[32]}, 32'd254);
        compare_mem("copy1_mem");

        run_op(8'd244, 8'd254, 8'd4, 1'b0, 8'd0, 0, 0);
        check("m254", {24'd0, mem[254]}, 32'd5);
        compare_mem("wrap_mem");

        run_op(8'd10, 8'd20, 8'd0, 1'b0, 8'd0, 0, 0);
        compare_mem("zero_len_mem");

        run_op(8'd16, 8'd50, 8'd3, 1'b0, 8'd0, 2, 0);
        compare_mem("ignored_start_mem");

        run_op(8'd16, 8'd40, 8'd4, 1'b0, 8'd0, 0, 3);
        check("m40", {24'd0, mem[40]}, 32'd254);
        compare_mem("mid_reset_mem");

`ifdef DMA_FILL_EN
        run_op(8'd0, 8'd100, 8'd3, 1'b1, 8'hAA, 0, 0);
        check("m101", {24'd0, mem[101]}, 32'hAA);
        compare_mem("fill_mem");
`endif

        for (int r = 0; r < 16; r++) begin
            logic [7:0] rs, rd8, rl;
            bit rf;
            for (int k = 0; k < 256; k++) ref_mem[k] = 8'($urandom);
            load_mem();
            rs  = 8'($urandom);
            rd8 = (r % 3 == 0) ? 8'(rs + 8'($urandom_range(1, 5))) : 8'($urandom);
            rl  = (r == 7) ? 8'd255 : 8'($urandom_range(0, 40));
`ifdef DMA_FILL_EN
            rf = bit'($urandom_range(0, 1));
`else
            rf = 1'b0;
`endif
            run_op(rs, rd8, rl, rf, 8'($urandom), 0, 0);
            compare_mem("rand_mem");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
